bcd_time_counter: RTL and testbench

//   Consumes the slow square wave from the clock divider (same clk domain) and keeps
//   an MM:SS time in packed BCD. Each qualifying edge of tick_in advances one second.

---
 rtl/bcd_time_pkg.sv | 18 +
 rtl/bcd_pair_counter.sv | 46 ++++
 rtl/bcd_time_counter.sv | 99 +++++++++
 tb/tb_bcd_time_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Shared constants and BCD helper functions for the MM:SS time counter.
package bcd_time_pkg;

  localparam int               BCD_W     = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
  localparam logic [7:0]       SEC_LIMIT = 8'h59;

  // True when both nibbles of a packed two-digit value are decimal digits.
  function automatic logic is_bcd(input logic [2*BCD_W-1:0] b);
    return (b[2*BCD_W-1:BCD_W] <= BCD_MAX) && (b[BCD_W-1:0] <= BCD_MAX);
  endfunction

  // Converts a decimal integer 0..99 into packed two-digit BCD.
  function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after LIMIT (LIMIT given in BCD).
// Priority: reset > clear > load > increment.
module bcd_pair_counter
  import bcd_time_pkg::*;
#(
  parameter logic [7:0] LIMIT = SEC_LIMIT
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_inc,
  output logic [7:0] o_value,
  output logic       o_carry
);

  logic [BCD_W-1:0] r_units;
  logic [BCD_W-1:0] r_tens;

  // Wrap signal for the next stage: only while actually incrementing from LIMIT.
  assign o_carry = i_inc && ({r_tens, r_units} == LIMIT);
  assign o_value = {r_tens, r_units};

  // Digit registers: decimal increment with units-to-tens carry, wrap at LIMIT.
  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_units <= '0;
      r_tens  <= '0;
    end else if (i_load) begin
      r_tens  <= i_load_val[7:4];
      r_units <= i_load_val[3:0];
    end else if (i_inc) begin
      if ({r_tens, r_units} == LIMIT) begin
        r_units <= '0;
        r_tens  <= '0;
      end else if (r_units == BCD_MAX) begin
        r_units <= '0;
        r_tens  <= r_tens + 4'd1;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// MM:SS packed-BCD time keeper driven by the divider's slow square wave.
// Each qualifying tick_in edge advances one second; supports run/stop,
// clear and a validated preset load with ack/err strobes.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter bit BOTH_EDGES = 1'b0,
  parameter int MIN_LIMIT  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       run,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       sec_pulse,
  output logic       rollover,
  output logic       load_ack,
  output logic       load_err
);

  localparam logic [7:0] MIN_LIMIT_BCD = to_bcd(MIN_LIMIT);

  logic r_tick_d;
  logic r_sec_pulse;
  logic r_rollover;
  logic r_load_ack;
  logic r_load_err;

  logic w_edge;
  logic w_load_valid;
  logic w_do_load;
  logic w_do_reject;
  logic w_do_adv;
  logic w_sec_carry;
  logic w_min_carry;

  // Delayed copy of tick_in; also tracks during reset so release never fakes an edge.
  always_ff @(posedge clk) begin
    r_tick_d <= tick_in;
  end

  assign w_edge = BOTH_EDGES ? (tick_in ^ r_tick_d) : (tick_in & ~r_tick_d);

  assign w_load_valid = is_bcd(load_min) && is_bcd(load_sec) &&
                        (load_sec <= SEC_LIMIT) && (load_min <= MIN_LIMIT_BCD);

  // Event resolution: clear beats load beats advance; losers are discarded.
  assign w_do_load   = load & ~clear & w_load_valid;
  assign w_do_reject = load & ~clear & ~w_load_valid;
  assign w_do_adv    = w_edge & run & ~clear & ~load;

  bcd_pair_counter #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk        (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .i_load     (w_do_load),
    .i_load_val (load_sec),
    .i_inc      (w_do_adv),
    .o_value    (sec),
    .o_carry    (w_sec_carry)
  );

  bcd_pair_counter #(.LIMIT(MIN_LIMIT_BCD)) u_min (
    .clk        (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .i_load     (w_do_load),
    .i_load_val (load_min),
    .i_inc      (w_sec_carry),
    .o_value    (min),
    .o_carry    (w_min_carry)
  );

  // One-cycle strobes, aligned with the cycle in which the time registers change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_pulse <= 1'b0;
      r_rollover  <= 1'b0;
      r_load_ack  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sec_pulse <= w_do_adv;
      r_rollover  <= w_min_carry;
      r_load_ack  <= w_do_load;
      r_load_err  <= w_do_reject;
    end
  end

  assign sec_pulse = r_sec_pulse;
  assign rollover  = r_rollover;
  assign load_ack  = r_load_ack;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: dut0 is the rising-edge build with MIN_LIMIT=59,
// dut1 is a both-edges build with MIN_LIMIT=5. Inputs are shared.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst, tick_in, run, clear, load;
  logic [7:0] load_min, load_sec;

  logic [7:0] min0, sec0, min1, sec1;
  logic       sp0, ro0, ack0, err0;
  logic       sp1, ro1, ack1, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.BOTH_EDGES(1'b0), .MIN_LIMIT(59)) dut0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .clear(clear),
    .load(load), .load_min(load_min), .load_sec(load_sec),
    .min(min0), .sec(sec0), .sec_pulse(sp0), .rollover(ro0),
    .load_ack(ack0), .load_err(err0)
  );

  bcd_time_counter #(.BOTH_EDGES(1'b1), .MIN_LIMIT(5)) dut1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .run(run), .clear(clear),
    .load(load), .load_min(load_min), .load_sec(load_sec),
    .min(min1), .sec(sec1), .sec_pulse(sp1), .rollover(ro1),
    .load_ack(ack1), .load_err(err1)
  );

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle preset request.
  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load_min = m;
    load_sec = s;
    load     = 1'b1;
    step();
    load     = 1'b0;
    $display("load %h:%h -> dut0 %h:%h ack=%0b err=%0b", m, s, min0, sec0, ack0, err0);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_in = 1'b1; run = 1'b1; clear = 1'b0; load = 1'b0;
    load_min = 8'h00; load_sec = 8'h00;
    step(); step();
    checks++; if ({min0, sec0} !== 16'h0000) begin errors++; $display("FAIL reset_time got %h exp 0000", {min0, sec0}); end
    checks++; if ({sp0, ro0, ack0, err0} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {sp0, ro0, ack0, err0}); end
    rst = 1'b0;
    step();
    checks++; if (sp0 !== 1'b0) begin errors++; $display("FAIL release_no_pulse got %b exp 0", sp0); end
    tick_in = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      tick_in = 1'b1;
      step();
      $display("rise %0d -> dut0 %h:%h pulse=%0b", i, min0, sec0, sp0);
      checks++; if (sp0 !== 1'b1) begin errors++; $display("FAIL t1_pulse%0d got %b exp 1", i, sp0); end
      checks++; if (sec0 !== 8'(i)) begin errors++; $display("FAIL t1_sec%0d got %h exp %h", i, sec0, 8'(i)); end
      tick_in = 1'b0;
      step();
      checks++; if (sp0 !== 1'b0) begin errors++; $display("FAIL t1_pulse_low%0d got %b exp 0", i, sp0); end
    end
    checks++; if ({min0, sec0} !== 16'h0003) begin errors++; $display("FAIL t1_final got %h exp 0003", {min0, sec0}); end
  endtask

  task automatic test_carry();
    do_load(8'h00, 8'h58);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL t2_ack got %b exp 1", ack0); end
    tick_in = 1'b1; step();
    checks++; if ({min0, sec0} !== 16'h0059) begin errors++; $display("FAIL t2_59 got %h exp 0059", {min0, sec0}); end
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    $display("carry -> dut0 %h:%h pulse=%0b roll=%0b", min0, sec0, sp0, ro0);
    checks++; if ({min0, sec0} !== 16'h0100) begin errors++; $display("FAIL t2_0100 got %h exp 0100", {min0, sec0}); end
    checks++; if ({sp0, ro0} !== 2'b10) begin errors++; $display("FAIL t2_strobes got %b exp 10", {sp0, ro0}); end
    tick_in = 1'b0; step();
  endtask

  task automatic test_rollover();
    do_load(8'h59, 8'h59);
    tick_in = 1'b1; step();
    $display("wrap -> dut0 %h:%h pulse=%0b roll=%0b", min0, sec0, sp0, ro0);
    checks++; if ({min0, sec0} !== 16'h0000) begin errors++; $display("FAIL t3_time got %h exp 0000", {min0, sec0}); end
    checks++; if ({sp0, ro0} !== 2'b11) begin errors++; $display("FAIL t3_strobes got %b exp 11", {sp0, ro0}); end
    tick_in = 1'b0; step();
    checks++; if (ro0 !== 1'b0) begin errors++; $display("FAIL t3_roll_low got %b exp 0", ro0); end
  endtask

  task automatic test_load_validation();
    do_load(8'h00, 8'h5A);
    checks++; if ({ack0, err0} !== 2'b01) begin errors++; $display("FAIL t4_5A got %b exp 01", {ack0, err0}); end
    do_load(8'h00, 8'h60);
    checks++; if ({ack0, err0} !== 2'b01) begin errors++; $display("FAIL t4_s60 got %b exp 01", {ack0, err0}); end
    do_load(8'h60, 8'h00);
    checks++; if ({ack0, err0} !== 2'b01) begin errors++; $display("FAIL t4_m60 got %b exp 01", {ack0, err0}); end
    checks++; if ({min0, sec0} !== 16'h0000) begin errors++; $display("FAIL t4_held got %h exp 0000", {min0, sec0}); end
    do_load(8'h12, 8'h34);
    checks++; if ({ack0, err0} !== 2'b10) begin errors++; $display("FAIL t4_ack got %b exp 10", {ack0, err0}); end
    checks++; if ({min0, sec0} !== 16'h1234) begin errors++; $display("FAIL t4_1234 got %h exp 1234", {min0, sec0}); end
    checks++; if ({ack1, err1} !== 2'b01) begin errors++; $display("FAIL t4_lim5_err got %b exp 01", {ack1, err1}); end
    // Held load: two consecutive requests, one good and one bad.
    load_min = 8'h07; load_sec = 8'h07; load = 1'b1;
    step();
    checks++; if ({ack0, err0, min0, sec0} !== {2'b10, 16'h0707}) begin errors++; $display("FAIL t4_hold1 got %b %h exp 10 0707", {ack0, err0}, {min0, sec0}); end
    load_sec = 8'h5A;
    step();
    load = 1'b0;
    $display("held load -> dut0 %h:%h ack=%0b err=%0b", min0, sec0, ack0, err0);
    checks++; if ({ack0, err0, min0, sec0} !== {2'b01, 16'h0707}) begin errors++; $display("FAIL t4_hold2 got %b %h exp 01 0707", {ack0, err0}, {min0, sec0}); end
  endtask

  task automatic test_priority();
    clear = 1'b1; tick_in = 1'b1;
    step();
    clear = 1'b0;
    checks++; if ({min0, sec0, sp0} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL t5_clear got %h %b exp 0000 0", {min0, sec0}, sp0); end
    tick_in = 1'b0; step();
    tick_in = 1'b1;
    do_load(8'h00, 8'h10);
    checks++; if ({min0, sec0, sp0, ack0} !== {16'h0010, 2'b01}) begin errors++; $display("FAIL t5_load_edge got %h %b%b exp 0010 01", {min0, sec0}, sp0, ack0); end
    tick_in = 1'b0; step();
    clear = 1'b1;
    do_load(8'h03, 8'h03);
    clear = 1'b0;
    checks++; if ({min0, sec0, ack0, err0} !== {16'h0000, 2'b00}) begin errors++; $display("FAIL t5_clear_load got %h %b exp 0000 00", {min0, sec0}, {ack0, err0}); end
  endtask

  task automatic test_run_stop();
    do_load(8'h00, 8'h20);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_in = 1'b1; step();
      checks++; if ({sec0, sp0} !== {8'h20, 1'b0}) begin errors++; $display("FAIL t6_frozen%0d got %h %b exp 20 0", i, sec0, sp0); end
      tick_in = 1'b0; step();
    end
    run = 1'b1;
    step();
    checks++; if (sec0 !== 8'h20) begin errors++; $display("FAIL t6_no_queue got %h exp 20", sec0); end
  endtask

  task automatic test_both_edges();
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick_in = ~tick_in;
      step();
      checks++; if ({sec1, sp1} !== {8'(i), 1'b1}) begin errors++; $display("FAIL t6b_edge%0d got %h %b exp %h 1", i, sec1, sp1, 8'(i)); end
    end
    $display("both edges -> dut1 %h:%h dut0 %h:%h", min1, sec1, min0, sec0);
    checks++; if (sec0 !== 8'h02) begin errors++; $display("FAIL t6b_rise_only got %h exp 02", sec0); end
    do_load(8'h05, 8'h59);
    checks++; if ({ack1, min1, sec1} !== {1'b1, 16'h0559}) begin errors++; $display("FAIL t6b_load got %b %h exp 1 0559", ack1, {min1, sec1}); end
    tick_in = 1'b1; step();
    checks++; if ({min1, sec1, ro1, sp1} !== {16'h0000, 2'b11}) begin errors++; $display("FAIL t6b_wrap5 got %h %b exp 0000 11", {min1, sec1}, {ro1, sp1}); end
    checks++; if ({min0, sec0, ro0} !== {16'h0600, 1'b0}) begin errors++; $display("FAIL t6b_dut0_0600 got %h %b exp 0600 0", {min0, sec0}, ro0); end
  endtask

  task automatic test_reset_mid();
    tick_in = 1'b0; step();
    tick_in = 1'b1; rst = 1'b1;
    do_load(8'h11, 8'h11);
    rst = 1'b0;
    checks++; if ({min0, sec0, sp0, ack0} !== {16'h0000, 2'b00}) begin errors++; $display("FAIL t7_rst got %h %b exp 0000 00", {min0, sec0}, {sp0, ack0}); end
    step();
    checks++; if (sp0 !== 1'b0) begin errors++; $display("FAIL t7_no_edge got %b exp 0", sp0); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_rollover();
    test_load_validation();
    test_priority();
    test_run_stop();
    test_both_edges();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
